// File: rtl/video_bank_scheduler.sv
// video_bank_scheduler: ping-pong scheduler for two multi-frame video banks.
// One bank is filled from the SPI pixel stream while the other plays to VGA.
// The roles swap once the fill is complete and the current playback is done.
//
// Ports:
//   CLK_40             system clock
//   reset              synchronous, active-high
//   start              single-cycle pulse, begins the first fill (IDLE only)
//   SPI_clk_en         pixel strobe from the SPI side
//   pixel_valid        SPI holds a pixel during this strobe
//   bank_read_done[1:0] per-bank pulse: the bank finished playing all frames
//   bank_write_enable  per-bank mode, 1 = fill, 0 = play
//   mem_x_pos          write column
//   mem_y_pos          write line
//   write_frame_idx    frame being filled within the fill bank
//   read_bank_sel      bank whose output feeds VGA
//   read_active        1 = VGA shows the read bank, 0 = VGA blanks
//   spi_ready          fill in progress, pixels accepted
//   underrun_count     number of playback underruns, saturating
//                      (present only with SCHED_STATUS_EN defined)
//
// Build option: define SCHED_STATUS_EN to add the underrun_count port and its counter.

module video_bank_scheduler #(
  parameter int unsigned X_WIDTH         = 160,
  parameter int unsigned Y_HEIGHT        = 120,
  parameter int unsigned FRAMES_PER_BANK = 15,
  localparam int unsigned X_ADDRW = (X_WIDTH > 1) ? $clog2(X_WIDTH) : 1,
  localparam int unsigned Y_ADDRW = (Y_HEIGHT > 1) ? $clog2(Y_HEIGHT) : 1,
  localparam int unsigned F_ADDRW = (FRAMES_PER_BANK > 1) ? $clog2(FRAMES_PER_BANK) : 1
`ifdef SCHED_STATUS_EN
  ,
  parameter int unsigned UNDERRUN_W      = 8
`endif
) (
  input  logic               CLK_40,
  input  logic               reset,
  input  logic               start,
  input  logic               SPI_clk_en,
  input  logic               pixel_valid,
  input  logic [1:0]         bank_read_done,
  output logic [1:0]         bank_write_enable,
  output logic [X_ADDRW-1:0] mem_x_pos,
  output logic [Y_ADDRW-1:0] mem_y_pos,
  output logic [F_ADDRW-1:0] write_frame_idx,
  output logic               read_bank_sel,
  output logic               read_active,
  output logic               spi_ready
`ifdef SCHED_STATUS_EN
  ,
  output logic [UNDERRUN_W-1:0] underrun_count
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRIME     = 3'd1,
    RUN       = 3'd2,
    WAIT_SWAP = 3'd3,
    STARVE    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [X_ADDRW-1:0]   x_q, x_d;
  logic [Y_ADDRW-1:0]   y_q, y_d;
  logic [F_ADDRW-1:0]   f_q, f_d;
  logic                 fill_done_q, fill_done_d;
  logic                 rbs_q, rbs_d;
  logic                 ra_q, ra_d;
  logic                 rdy_q, rdy_d;
  logic [1:0]           we_q, we_d;
`ifdef SCHED_STATUS_EN
  logic [UNDERRUN_W-1:0] und_q, und_d;
`endif

  logic accept;
  logic rd_r;
  logic do_swap;
  logic do_clear;

  // Next-state, counter chain and registered-output computation
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    f_d         = f_q;
    fill_done_d = fill_done_q;
    rbs_d       = rbs_q;
    we_d        = 2'b00;
    ra_d        = 1'b0;
    rdy_d       = 1'b0;
`ifdef SCHED_STATUS_EN
    und_d       = und_q;
`endif
    do_swap     = 1'b0;
    do_clear    = 1'b0;
    accept      = SPI_clk_en & pixel_valid & rdy_q;
    // Only the playing bank's done pulse matters; the fill bank's is ignored
    rd_r        = bank_read_done[rbs_q];

    if (accept) begin
      if (x_q == X_ADDRW'(X_WIDTH - 1)) begin
        x_d = '0;
        if (y_q == Y_ADDRW'(Y_HEIGHT - 1)) begin
          y_d = '0;
          if (f_q == F_ADDRW'(FRAMES_PER_BANK - 1)) begin
            f_d         = '0;
            fill_done_d = 1'b1;
          end else begin
            f_d = f_q + 1'b1;
          end
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PRIME;
          do_clear = 1'b1;
        end
      end
      PRIME: begin
        if (fill_done_q) begin
          state_d  = RUN;
          rbs_d    = 1'b0;
          do_clear = 1'b1;
        end
      end
      RUN: begin
        if (fill_done_q && rd_r) begin
          do_swap = 1'b1;
        end else if (fill_done_q) begin
          state_d = WAIT_SWAP;
        end else if (rd_r) begin
          state_d = STARVE;
`ifdef SCHED_STATUS_EN
          if (und_q != '1) und_d = und_q + 1'b1;
`endif
        end
      end
      WAIT_SWAP: begin
        if (rd_r) begin
          state_d = RUN;
          do_swap = 1'b1;
        end
      end
      STARVE: begin
        // Reader replays bank R on its own; swap waits for its next done
        if (fill_done_q) state_d = WAIT_SWAP;
      end
      default: state_d = IDLE;
    endcase

    if (do_swap) begin
      rbs_d    = ~rbs_q;
      do_clear = 1'b1;
    end
    if (do_clear) begin
      x_d         = '0;
      y_d         = '0;
      f_d         = '0;
      fill_done_d = 1'b0;
    end

    // Outputs follow the next state; spi_ready drops as soon as the fill completes
    case (state_d)
      PRIME: begin
        we_d  = 2'b01;
        rdy_d = ~fill_done_d;
      end
      RUN, STARVE: begin
        we_d  = rbs_d ? 2'b01 : 2'b10;
        ra_d  = 1'b1;
        rdy_d = ~fill_done_d;
      end
      WAIT_SWAP: begin
        we_d = rbs_d ? 2'b01 : 2'b10;
        ra_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      f_q         <= '0;
      fill_done_q <= 1'b0;
      rbs_q       <= 1'b0;
      ra_q        <= 1'b0;
      rdy_q       <= 1'b0;
      we_q        <= 2'b00;
`ifdef SCHED_STATUS_EN
      und_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      f_q         <= f_d;
      fill_done_q <= fill_done_d;
      rbs_q       <= rbs_d;
      ra_q        <= ra_d;
      rdy_q       <= rdy_d;
      we_q        <= we_d;
`ifdef SCHED_STATUS_EN
      und_q       <= und_d;
`endif
    end
  end

  assign bank_write_enable = we_q;
  assign mem_x_pos         = x_q;
  assign mem_y_pos         = y_q;
  assign write_frame_idx   = f_q;
  assign read_bank_sel     = rbs_q;
  assign read_active       = ra_q;
  assign spi_ready         = rdy_q;
`ifdef SCHED_STATUS_EN
  assign underrun_count    = und_q;
`endif

endmodule

// File: tb/tb_video_bank_scheduler.sv
// tb_video_bank_scheduler: scoreboard bench for video_bank_scheduler
// (X=4, Y=2, FRAMES=3 build). The driver applies inputs on the falling edge,
// steps a pixel-count reference model and queues the expected outputs; a
// monitor pops one entry after each rising edge and compares.

module tb_video_bank_scheduler;

  localparam int XS = 4;
  localparam int YS = 2;
  localparam int FS = 3;
  localparam int TOTAL = XS * YS * FS;
  localparam int XW = 2;
  localparam int YW = 1;
  localparam int FW = 2;

  typedef struct packed {
    logic [1:0]    we;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [FW-1:0] f;
    logic          rbs;
    logic          ra;
    logic          rdy;
    logic [7:0]    und;
  } obs_t;

  typedef enum int {M_IDLE, M_PRIME, M_RUN, M_WAIT, M_STARVE} mode_t;

  logic          clk = 1'b0;
  logic          reset, start, spi_clk_en, pixel_valid;
  logic [1:0]    bank_read_done;
  logic [1:0]    bank_write_enable;
  logic [XW-1:0] mem_x_pos;
  logic [YW-1:0] mem_y_pos;
  logic [FW-1:0] write_frame_idx;
  logic          read_bank_sel, read_active, spi_ready;
`ifdef SCHED_STATUS_EN
  logic [7:0]    underrun_count;
`endif

  video_bank_scheduler #(
    .X_WIDTH(XS), .Y_HEIGHT(YS), .FRAMES_PER_BANK(FS)
  ) dut (
    .CLK_40(clk), .reset(reset), .start(start), .SPI_clk_en(spi_clk_en),
    .pixel_valid(pixel_valid), .bank_read_done(bank_read_done),
    .bank_write_enable(bank_write_enable), .mem_x_pos(mem_x_pos),
    .mem_y_pos(mem_y_pos), .write_frame_idx(write_frame_idx),
    .read_bank_sel(read_bank_sel), .read_active(read_active),
    .spi_ready(spi_ready)
`ifdef SCHED_STATUS_EN
    , .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a count of pixels written into the current fill
  mode_t m_mode = M_IDLE;
  int    m_cnt  = 0;
  bit    m_full = 1'b0;
  bit    m_rbs  = 1'b0;
  int    m_und  = 0;

  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    done   = 1'b0;
  int    n_swaps = 0, n_starve = 0, n_wait = 0;

  function automatic bit m_ready();
    return (m_mode == M_PRIME || m_mode == M_RUN || m_mode == M_STARVE) && !m_full;
  endfunction

  function automatic obs_t m_outputs();
    obs_t o;
    o.we  = (m_mode == M_IDLE) ? 2'b00 :
            (m_mode == M_PRIME) ? 2'b01 :
            (m_rbs ? 2'b01 : 2'b10);
    o.x   = XW'(m_cnt % XS);
    o.y   = YW'((m_cnt / XS) % YS);
    o.f   = FW'(m_cnt / (XS * YS));
    o.rbs = m_rbs;
    o.ra  = (m_mode == M_RUN || m_mode == M_WAIT || m_mode == M_STARVE);
    o.rdy = m_ready();
`ifdef SCHED_STATUS_EN
    o.und = 8'(m_und);
`else
    o.und = 8'd0;
`endif
    return o;
  endfunction

  task automatic do_swap();
    m_rbs  = ~m_rbs;
    m_cnt  = 0;
    m_full = 1'b0;
    n_swaps++;
  endtask

  // Apply one cycle of inputs and predict the outputs after the next rising edge
  task automatic tick(input bit st, input bit en, input bit pv, input bit [1:0] rd, input bit rs);
    bit acc, rd_r;
    @(negedge clk);
    reset = rs; start = st; spi_clk_en = en; pixel_valid = pv; bank_read_done = rd;
    if (rs) begin
      m_mode = M_IDLE; m_cnt = 0; m_full = 1'b0; m_rbs = 1'b0; m_und = 0;
    end else begin
      acc  = en && pv && m_ready();
      rd_r = rd[m_rbs];
      case (m_mode)
        M_IDLE:   if (st) begin m_mode = M_PRIME; m_cnt = 0; m_full = 1'b0; end
        M_PRIME:  if (m_full) begin m_mode = M_RUN; m_cnt = 0; m_full = 1'b0; m_rbs = 1'b0; end
        M_RUN: begin
          if (m_full && rd_r) do_swap();
          else if (m_full) begin m_mode = M_WAIT; n_wait++; end
          else if (rd_r) begin
            m_mode = M_STARVE; n_starve++;
            if (m_und < 255) m_und++;
          end
        end
        M_WAIT:   if (rd_r) begin do_swap(); m_mode = M_RUN; end
        M_STARVE: if (m_full) begin m_mode = M_WAIT; n_wait++; end
        default:  ;
      endcase
      if (acc) begin
        m_cnt++;
        if (m_cnt == TOTAL) begin m_cnt = 0; m_full = 1'b1; end
      end
    end
    exp_q.push_back(m_outputs());
  endtask

  function automatic bit [1:0] rd_of(input bit b);
    return b ? 2'b10 : 2'b01;
  endfunction

  // Feed pixels until the model reports the fill complete (bounded)
  task automatic fill_to_full();
    for (int i = 0; i < 4 * TOTAL && !m_full; i++) tick(0, 1, 1, 2'b00, 0);
  endtask

  // Monitor: compare DUT outputs with the queued prediction after each edge
  initial begin : monitor
    obs_t e, a;
    int cyc = 0;
    while (!(done && exp_q.size() == 0) && cyc < 50000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.we = bank_write_enable; a.x = mem_x_pos; a.y = mem_y_pos;
        a.f = write_frame_idx; a.rbs = read_bank_sel; a.ra = read_active;
        a.rdy = spi_ready;
`ifdef SCHED_STATUS_EN
        a.und = underrun_count;
`else
        a.und = 8'd0;
`endif
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cyc%0d: got we=%b x=%0d y=%0d f=%0d rbs=%b ra=%b rdy=%b und=%0d, expected we=%b x=%0d y=%0d f=%0d rbs=%b ra=%b rdy=%b und=%0d",
                   cyc, a.we, a.x, a.y, a.f, a.rbs, a.ra, a.rdy, a.und,
                   e.we, e.x, e.y, e.f, e.rbs, e.ra, e.rdy, e.und);
        end
      end
    end
    if (!(done && exp_q.size() == 0)) begin
      errors++;
      $display("FAIL timeout: got pending=%0d, expected 0", exp_q.size());
    end
    checks++;
    if (n_swaps < 3 || n_starve < 1 || n_wait < 1) begin
      errors++;
      $display("FAIL scenario_coverage: got swaps=%0d starve=%0d wait=%0d, expected >=3/>=1/>=1",
               n_swaps, n_starve, n_wait);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Driver
  initial begin : driver
    reset = 1'b1; start = 1'b0; spi_clk_en = 1'b0; pixel_valid = 1'b0; bank_read_done = 2'b00;
    repeat (3) tick(0, 0, 0, 2'b00, 1);
    tick(1, 0, 0, 2'b00, 0);                 // begin priming bank 0
    fill_to_full();                          // 24 accepts
    repeat (2) tick(0, 1, 1, 2'b00, 0);      // into RUN, filling bank 1
    // Fill completes before playback: WAIT_SWAP, then swap on read done
    fill_to_full();
    repeat (3) tick(0, 1, 1, 2'b00, 0);
    tick(0, 1, 1, rd_of(m_rbs), 0);
    tick(0, 0, 0, 2'b00, 0);
    // Playback ends at 10 pixels: STARVE, finish fill, swap on next done
    repeat (10) tick(0, 1, 1, 2'b00, 0);
    tick(0, 0, 0, rd_of(m_rbs), 0);
    fill_to_full();
    repeat (2) tick(0, 1, 1, 2'b00, 0);
    tick(0, 0, 0, rd_of(m_rbs), 0);
    // Fill done and read done on the same cycle: direct swap
    fill_to_full();
    tick(0, 1, 1, rd_of(m_rbs), 0);
    tick(0, 1, 1, 2'b00, 0);
    // No strobe / no valid: counters hold; fill-bank done ignored; stray start ignored
    repeat (5) tick(0, 1, 0, 2'b00, 0);
    repeat (5) tick(0, 0, 1, 2'b00, 0);
    tick(0, 0, 0, rd_of(~m_rbs), 0);
    tick(1, 0, 0, 2'b00, 0);
    // Reset mid-RUN at x=3, y=1, then restart
    for (int i = 0; i < 4 * TOTAL && !(m_mode == M_RUN && m_cnt == 7); i++) tick(0, 1, 1, 2'b00, 0);
    tick(0, 0, 0, 2'b00, 1);
    tick(0, 0, 0, 2'b00, 0);
    tick(1, 0, 0, 2'b00, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) != 0),
           {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)},
           ($urandom_range(0, 499) == 0));
    end
    done = 1'b1;
  end

endmodule
